i2c_multichannel_scheduler: RTL and testbench
=============================================

Name: i2c_multichannel_scheduler

Overview:
- Parametrised successor to the single-slave master controller.
- Services NUM_CH independent I2C slave channels round-robin, each with its own device address, register pointer, byte count and direction.
- Drives the existing I2C master go/done/ready handshake, moving data between the master and a shared channel-partitioned RAM.
- Adds NACK retry, per-transaction timeout and abort, and per-channel error flags.

Parameters:
NUM_CH, 4, number of slave channels (1..8)
MAX_BYTES, 8, bytes per channel RAM window; power of 2, ≤32
RETRY_MAX, 3, re-attempts after NACK before channel is flagged
TIMEOUT_CYC, 100000, clk cycles allowed from go to done
RAM_AW, 8, RAM address width; must satisfy NUM_CH*MAX_BYTES ≤ 2^RAM_AW

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  scheduler run enable
ch_en  in  NUM_CH  per-channel enable
ch_rw  in  NUM_CH  1=read slave, 0=write slave
ch_dev_add  in  7*NUM_CH  packed 7-bit slave addresses, channel 0 in LSBs
ch_reg_ptr  in  8*NUM_CH  packed slave register pointers
ch_nbytes  in  6*NUM_CH  packed byte counts
err_clr  in  1  clears all ch_err bits
m_go  out  1  one-cycle start pulse to master
m_rw  out  1  transaction direction
m_nbyte  out  6  transaction byte count
m_dev_add  out  7  slave address
m_rpointer  out  8  slave register pointer
m_dwr  out  8  write data byte
m_stop  out  1  one-cycle abort pulse
m_done  in  1  transaction-complete pulse
m_ready  in  1  byte-boundary pulse: read byte valid on m_drd / next write byte consumed
m_ack_e  in  1  NACK error, valid with m_done
m_drd  in  8  read data
ram_add  out  RAM_AW  shared RAM address
ram_din  out  8  RAM write data
ram_w  out  1  RAM write strobe
ram_rdout  in  8  RAM read data, 1-cycle latency from ram_add
busy  out  1  transaction in progress
sweep_done  out  1  one-cycle pulse at end of each round-robin sweep
ch_err  out  NUM_CH  sticky per-channel failure flags

Behaviour:
- Reset (reset=0 at clk edge): every output is 0; state IDLE; channel pointer=0; retry and timeout counters=0. Reset mid-transaction aborts immediately with no m_stop.
- Channel c RAM window: base c*MAX_BYTES; byte k at base+k.
- Effective count n = min(ch_nbytes[c], MAX_BYTES). Channels with n=0 or ch_en[c]=0 are skipped with no bus activity.
- IDLE: if enable=1 and any ch_en bit set, go to SELECT; otherwise stay, busy=0.
- SELECT: pick next enabled channel with n>0, searching from the pointer upward with wrap. Latch dev_add, reg_ptr, rw and n into the m_* outputs. Read goes to GO; write goes to FETCH.
- FETCH: ram_add=base; two cycles later m_dwr=ram_rdout; go to GO.
- GO: m_go=1 for exactly one cycle; busy=1; byte index=0; timeout counter=0; go to XFER.
- XFER, read: on each m_ready, ram_add=base+index, ram_din=m_drd, ram_w=1 for one cycle, then index++.
- XFER, write: on each m_ready, index++ and prefetch base+index. m_dwr updates within 2 cycles of m_ready. No fetch is issued past index n-1.
- Every m_ready pulse beyond n in a transaction is ignored; no RAM write and no address change.
- m_done in XFER goes to CHECK. If m_ready and m_done arrive together, the byte is processed first, then the transition is taken.
- Timeout: if the counter reaches TIMEOUT_CYC-1 in XFER, m_stop=1 for one cycle. The channel's ch_err is set, retries are abandoned, and the scheduler goes to NEXT.
- CHECK:
  - m_ack_e=0: clear ch_err[c] and retry count, go to NEXT.
  - m_ack_e=1 and retry<RETRY_MAX: retry++, go to GO. The write path restarts at FETCH.
  - m_ack_e=1 and retry=RETRY_MAX: set ch_err[c], clear retry, go to NEXT.
- NEXT: busy=0; pointer=c+1 mod NUM_CH.
  - sweep_done=1 for one cycle if no enabled non-zero channel exists with index >c.
  - Return to IDLE if enable=0, else SELECT.
- enable falling mid-transaction: the current transaction, including retries, completes; then the scheduler goes to IDLE.
- Channel configuration inputs are sampled only in SELECT. Changes during a transaction take effect on the next visit.
- err_clr has priority over a set in the same cycle; the set is lost.
- Single enabled channel: serviced back-to-back, with sweep_done after every transaction.

Test Plan:
- NUM_CH=4; ch_en=4'b0101; ch0 read 3 bytes dev 0x48 ptr 0x00; ch2 write 2 bytes dev 0x50 ptr 0x10; RAM[16]=0xA5, RAM[17]=0x3C. Expect m_go for ch0, then ch2. Bytes 0x11,0x22,0x33 land at RAM 0..2; m_dwr shows 0xA5 then 0x3C; sweep_done after ch2.
- ch1 only; model NACKs every attempt. Expect exactly 4 m_go pulses (1+RETRY_MAX), then ch_err=4'b0010. A later successful pass clears the bit.
- Model NACKs twice, then ACKs. Expect 3 m_go pulses, ch_err remains 0, RAM written once.
- Model never returns m_done; TIMEOUT_CYC=50. Expect m_stop 50 cycles after m_go, ch_err set, next channel serviced.
- ch_nbytes=12 with MAX_BYTES=8: m_nbyte=8, and extra m_ready pulses produce no ram_w. ch_nbytes=0 channel: no m_go.
- Assert reset=0 mid-XFER, then deassert; also drop enable mid-XFER. After reset: all outputs 0, restart at ch0. After enable drop: transaction finishes, busy=0, IDLE.

Source files
------------

// File: rtl/i2c_multichannel_scheduler.sv
// Round-robin scheduler that walks NUM_CH slave channels through a shared I2C master,
// moving bytes between the master and per-channel windows of a shared RAM.
module i2c_multichannel_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int MAX_BYTES   = 8,
  parameter int RETRY_MAX   = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter int RAM_AW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH-1:0]   ch_rw,
  input  logic [7*NUM_CH-1:0] ch_dev_add,
  input  logic [8*NUM_CH-1:0] ch_reg_ptr,
  input  logic [6*NUM_CH-1:0] ch_nbytes,
  input  logic                err_clr,
  output logic                m_go,
  output logic                m_rw,
  output logic [5:0]          m_nbyte,
  output logic [6:0]          m_dev_add,
  output logic [7:0]          m_rpointer,
  output logic [7:0]          m_dwr,
  output logic                m_stop,
  input  logic                m_done,
  input  logic                m_ready,
  input  logic                m_ack_e,
  input  logic [7:0]          m_drd,
  output logic [RAM_AW-1:0]   ram_add,
  output logic [7:0]          ram_din,
  output logic                ram_w,
  input  logic [7:0]          ram_rdout,
  output logic                busy,
  output logic                sweep_done,
  output logic [NUM_CH-1:0]   ch_err
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [CW:0]     NUM_CH_W  = (CW+1)'(NUM_CH);
  localparam logic [CW-1:0]   LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [5:0]      MAX_N     = 6'(MAX_BYTES);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0]   RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [RAM_AW-1:0] WIN     = RAM_AW'(MAX_BYTES);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] FETCH  = 3'd2;
  localparam logic [2:0] GO     = 3'd3;
  localparam logic [2:0] XFER   = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] NEXT   = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] cur;
  logic [5:0]    curN;
  logic [5:0]    idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmo;
  logic [1:0]    fetchPipe;
  logic          ackErr;

  logic [5:0]        effN   [NUM_CH];
  logic [6:0]        devArr [NUM_CH];
  logic [7:0]        regArr [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] above;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gCh
      logic [5:0] rawN;
      assign rawN        = ch_nbytes[gi*6 +: 6];
      assign effN[gi]    = (rawN > MAX_N) ? MAX_N : rawN;
      assign devArr[gi]  = ch_dev_add[gi*7 +: 7];
      assign regArr[gi]  = ch_reg_ptr[gi*8 +: 8];
      assign elig[gi]    = ch_en[gi] && (effN[gi] != 6'd0);
      assign above[gi]   = elig[gi] && (cur < CW'(gi));
    end
  endgenerate

  // Rotate eligibility so bit 0 is the pointer position; lowest set bit wins.
  logic [2*NUM_CH-1:0] eligDbl;
  logic [CW-1:0]       selOff;
  logic                selFound;
  logic [CW:0]         selSum;
  logic [CW-1:0]       selCh;
  assign eligDbl = {elig, elig} >> ptr;

  always_comb begin
    selFound = 1'b0;
    selOff   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligDbl[i]) begin
        selFound = 1'b1;
        selOff   = CW'(i);
      end
    end
  end

  assign selSum = {1'b0, ptr} + {1'b0, selOff};
  assign selCh  = (selSum >= NUM_CH_W) ? CW'(selSum - NUM_CH_W) : CW'(selSum);

  logic [RAM_AW-1:0] baseAddr;
  logic [RAM_AW-1:0] selBase;
  logic [5:0]        nextIdx;
  logic [CW-1:0]     nextPtr;
  logic              tmoHit;
  assign baseAddr = RAM_AW'(cur) * WIN;
  assign selBase  = RAM_AW'(selCh) * WIN;
  assign nextIdx  = idx + 6'd1;
  assign nextPtr  = (cur == LAST_CH) ? '0 : cur + 1'b1;
  assign tmoHit   = (state == XFER) && !m_done && (tmo == TMO_LAST);

  logic errSetNow;
  logic errOkNow;
  always_comb begin
    errSetNow = tmoHit;
    errOkNow  = 1'b0;
    if (state == CHECK) begin
      if (!ackErr)                 errOkNow  = 1'b1;
      else if (retry >= RETRY_LIM) errSetNow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cur        <= '0;
      curN       <= '0;
      idx        <= '0;
      retry      <= '0;
      tmo        <= '0;
      fetchPipe  <= '0;
      ackErr     <= 1'b0;
      m_go       <= 1'b0;
      m_rw       <= 1'b0;
      m_nbyte    <= '0;
      m_dev_add  <= '0;
      m_rpointer <= '0;
      m_dwr      <= '0;
      m_stop     <= 1'b0;
      ram_add    <= '0;
      ram_din    <= '0;
      ram_w      <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      m_go       <= 1'b0;
      m_stop     <= 1'b0;
      ram_w      <= 1'b0;
      sweep_done <= 1'b0;
      // Two-stage tracker for RAM reads: address issued, then data valid.
      fetchPipe  <= {fetchPipe[0], 1'b0};
      if (fetchPipe[1]) m_dwr <= ram_rdout;

      case (state)
        IDLE: if (enable && (|ch_en)) state <= SELECT;
        SELECT: begin
          if (selFound) begin
            cur        <= selCh;
            curN       <= effN[selCh];
            m_nbyte    <= effN[selCh];
            m_dev_add  <= devArr[selCh];
            m_rpointer <= regArr[selCh];
            m_rw       <= ch_rw[selCh];
            if (ch_rw[selCh]) begin
              state <= GO;
            end else begin
              ram_add   <= selBase;
              fetchPipe <= 2'b01;
              state     <= FETCH;
            end
          end else begin
            state <= IDLE;
          end
        end
        FETCH: if (fetchPipe[1]) state <= GO;
        GO: begin
          m_go  <= 1'b1;
          busy  <= 1'b1;
          idx   <= '0;
          tmo   <= '0;
          state <= XFER;
        end
        XFER: begin
          if (m_ready && (idx < curN)) begin
            idx <= nextIdx;
            if (m_rw) begin
              ram_add <= baseAddr + RAM_AW'(idx);
              ram_din <= m_drd;
              ram_w   <= 1'b1;
            end else if (nextIdx < curN) begin
              ram_add   <= baseAddr + RAM_AW'(nextIdx);
              fetchPipe <= {fetchPipe[0], 1'b1};
            end
          end
          if (m_done) begin
            ackErr <= m_ack_e;
            state  <= CHECK;
          end else if (tmoHit) begin
            m_stop <= 1'b1;
            retry  <= '0;
            state  <= NEXT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CHECK: begin
          if (!ackErr || (retry >= RETRY_LIM)) begin
            retry <= '0;
            state <= NEXT;
          end else begin
            retry <= retry + 1'b1;
            if (m_rw) begin
              state <= GO;
            end else begin
              ram_add   <= baseAddr;
              fetchPipe <= 2'b01;
              state     <= FETCH;
            end
          end
        end
        NEXT: begin
          busy       <= 1'b0;
          ptr        <= nextPtr;
          sweep_done <= ~(|above);
          state      <= enable ? SELECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)         ch_err      <= '0;
    else if (err_clr)   ch_err      <= '0;
    else if (errSetNow) ch_err[cur] <= 1'b1;
    else if (errOkNow)  ch_err[cur] <= 1'b0;
  end

endmodule

// File: tb/tb_i2c_multichannel_scheduler.sv
// Randomized bench: a master/slave bus model drives the scheduler while a channel-level
// model predicts selection order, RAM contents, error flags and pulse counts.
module tb_i2c_multichannel_scheduler;
  localparam int NUM_CH = 4, MAX_BYTES = 8, RETRY_MAX = 3, TIMEOUT_CYC = 50, RAM_AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, err_clr, m_done, m_ready, m_ack_e;
  logic [NUM_CH-1:0] ch_en, ch_rw, ch_err;
  logic [7*NUM_CH-1:0] ch_dev_add;
  logic [8*NUM_CH-1:0] ch_reg_ptr;
  logic [6*NUM_CH-1:0] ch_nbytes;
  logic m_go, m_rw, m_stop, ram_w, busy, sweep_done;
  logic [5:0] m_nbyte;
  logic [6:0] m_dev_add;
  logic [7:0] m_rpointer, m_dwr, m_drd, ram_din, ram_rdout;
  logic [RAM_AW-1:0] ram_add;

  i2c_multichannel_scheduler #(
    .NUM_CH(NUM_CH), .MAX_BYTES(MAX_BYTES), .RETRY_MAX(RETRY_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RAM_AW(RAM_AW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_en(ch_en), .ch_rw(ch_rw),
    .ch_dev_add(ch_dev_add), .ch_reg_ptr(ch_reg_ptr), .ch_nbytes(ch_nbytes),
    .err_clr(err_clr), .m_go(m_go), .m_rw(m_rw), .m_nbyte(m_nbyte),
    .m_dev_add(m_dev_add), .m_rpointer(m_rpointer), .m_dwr(m_dwr), .m_stop(m_stop),
    .m_done(m_done), .m_ready(m_ready), .m_ack_e(m_ack_e), .m_drd(m_drd),
    .ram_add(ram_add), .ram_din(ram_din), .ram_w(ram_w), .ram_rdout(ram_rdout),
    .busy(busy), .sweep_done(sweep_done), .ch_err(ch_err)
  );

  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_w) ram[ram_add] <= ram_din;
    ram_rdout <= ram[ram_add];
  end

  int goCnt = 0, sweepCnt = 0, ramWCnt = 0, stopCnt = 0;
  always @(posedge clk) begin
    if (m_go === 1'b1)       goCnt    <= goCnt + 1;
    if (sweep_done === 1'b1) sweepCnt <= sweepCnt + 1;
    if (ram_w === 1'b1)      ramWCnt  <= ramWCnt + 1;
    if (m_stop === 1'b1)     stopCnt  <= stopCnt + 1;
  end

  logic [7:0] modelRam [0:255];
  logic [NUM_CH-1:0] modelErr;
  int modelPtr, expGo, expSweep, expRamW, expStop;
  int vectors = 0, miscompares = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int effN(input int c);
    int raw;
    raw = int'(ch_nbytes[c*6 +: 6]);
    return (raw > MAX_BYTES) ? MAX_BYTES : raw;
  endfunction

  function automatic bit elig(input int c);
    return ch_en[c] && (effN(c) > 0);
  endfunction

  function automatic int pickCh();
    for (int k = 0; k < NUM_CH; k++)
      if (elig((modelPtr + k) % NUM_CH)) return (modelPtr + k) % NUM_CH;
    return 0;
  endfunction

  function automatic bit anyAbove(input int c);
    for (int j = c + 1; j < NUM_CH; j++) if (elig(j)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] allOutputs();
    return 64'({m_go, m_rw, m_nbyte, m_dev_add, m_rpointer, m_dwr, m_stop,
                ram_add, ram_din, ram_w, busy, sweep_done, ch_err});
  endfunction

  task automatic waitGo(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_go === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic busPulse(input logic rdy, input logic [7:0] data, input logic done, input logic nack);
    m_ready = rdy; m_drd = data; m_done = done; m_ack_e = nack;
    @(negedge clk);
    m_ready = 1'b0; m_done = 1'b0; m_ack_e = 1'b0;
  endtask

  // One visit: the channel the model expects, with nNack NACKed attempts first,
  // optionally hanging the first attempt, then extra ready pulses beyond the count.
  task automatic doVisit(input int nNack, input bit hang, input int extra, input bit dropEn);
    int c, n, base, total, cyc;
    bit ok, failed, coincide;
    logic [7:0] d;
    c = pickCh(); n = effN(c); base = c * MAX_BYTES;
    failed = 1'b0;
    for (int a = 0; a <= RETRY_MAX; a++) begin
      waitGo(ok);
      checkVal($sformatf("go_seen ch%0d att%0d", c, a), 64'(ok), 64'd1);
      if (!ok) return;
      expGo++;
      if (a == 0) begin
        checkVal("sweep_count", 64'(sweepCnt), 64'(expSweep));
        checkVal("ch_err_prev", 64'(ch_err), 64'(modelErr));
        if (dropEn) enable = 1'b0;
      end
      checkVal("m_dev_add", 64'(m_dev_add), 64'(ch_dev_add[c*7 +: 7]));
      checkVal("m_rpointer", 64'(m_rpointer), 64'(ch_reg_ptr[c*8 +: 8]));
      checkVal("m_rw", 64'(m_rw), 64'(ch_rw[c]));
      checkVal("m_nbyte", 64'(m_nbyte), 64'(n));
      checkVal("busy_xfer", 64'(busy), 64'd1);
      if (hang) begin
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (m_stop !== 1'b1 && cyc < 200);
        checkVal("timeout_cycles", 64'(cyc), 64'(TIMEOUT_CYC));
        expStop++; failed = 1'b1;
        break;
      end
      if (a < nNack) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        busPulse(1'b0, 8'h00, 1'b1, 1'b1);
        failed = (a == RETRY_MAX);
        continue;
      end
      total = n + extra;
      coincide = 1'($urandom_range(0, 1));
      for (int i = 0; i < total; i++) begin
        repeat ($urandom_range(2, 4)) @(negedge clk);
        if (!ch_rw[c] && i < n)
          checkVal($sformatf("m_dwr ch%0d b%0d", c, i), 64'(m_dwr), 64'(modelRam[base+i]));
        d = 8'($urandom);
        if (ch_rw[c] && i < n) begin modelRam[base+i] = d; expRamW++; end
        busPulse(1'b1, d, coincide && (i == total - 1), 1'b0);
      end
      if (!(coincide && total > 0)) begin
        repeat ($urandom_range(1, 2)) @(negedge clk);
        busPulse(1'b0, 8'h00, 1'b1, 1'b0);
      end
      break;
    end
    modelErr[c] = failed;
    if (!anyAbove(c)) expSweep++;
    modelPtr = (c + 1) % NUM_CH;
    $display("txn ch%0d rw=%0d n=%0d nacks=%0d hang=%0d err=%0d", c, ch_rw[c], n, nNack, hang, failed);
  endtask

  task automatic setCfg(input logic [3:0] en, input logic [3:0] rw, input logic [27:0] dev,
                        input logic [31:0] ptrs, input logic [23:0] nb);
    ch_en = en; ch_rw = rw; ch_dev_add = dev; ch_reg_ptr = ptrs; ch_nbytes = nb;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic endPhase();
    repeat (12) @(negedge clk);
    checkVal("busy_idle", 64'(busy), 64'd0);
    checkVal("go_count", 64'(goCnt), 64'(expGo));
    checkVal("sweep_count_end", 64'(sweepCnt), 64'(expSweep));
    checkVal("ramw_count", 64'(ramWCnt), 64'(expRamW));
    checkVal("stop_count", 64'(stopCnt), 64'(expStop));
    checkVal("ch_err_end", 64'(ch_err), 64'(modelErr));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b0; enable = 1'b0; err_clr = 1'b0; m_done = 1'b0; m_ready = 1'b0;
    m_ack_e = 1'b0; m_drd = '0; ch_en = '0; ch_rw = '0; ch_dev_add = '0;
    ch_reg_ptr = '0; ch_nbytes = '0;
    for (int i = 0; i < 256; i++) begin ram[i] = 8'($urandom); modelRam[i] = ram[i]; end
    ram[16] = 8'hA5; modelRam[16] = 8'hA5; ram[17] = 8'h3C; modelRam[17] = 8'h3C;
    modelPtr = 0; modelErr = '0; expGo = 0; expSweep = 0; expRamW = 0; expStop = 0;
    repeat (3) @(negedge clk);
    checkVal("reset_outputs", allOutputs(), 64'd0);
    reset = 1'b1;

    // ch0 read 3 @0x48/0x00, ch2 write 2 @0x50/0x10
    setCfg(4'b0101, 4'b0001, {7'h00, 7'h50, 7'h00, 7'h48},
           {8'h00, 8'h10, 8'h00, 8'h00}, {6'd0, 6'd2, 6'd0, 6'd3});
    doVisit(0, 0, 0, 0);
    doVisit(0, 0, 0, 1);
    endPhase();

    // ch1 NACKs on every attempt, then a clean pass, then NACK twice before ACK
    setCfg(4'b0010, 4'b0010, {7'h00, 7'h00, 7'h2A, 7'h00},
           {8'h00, 8'h00, 8'h33, 8'h00}, {6'd0, 6'd0, 6'd4, 6'd0});
    doVisit(9, 0, 0, 0);
    doVisit(0, 0, 0, 0);
    doVisit(2, 0, 0, 1);
    endPhase();

    // hang on ch0, ch1 must still be serviced
    setCfg(4'b0011, 4'b0011, {7'h00, 7'h00, 7'h11, 7'h22},
           {8'h00, 8'h00, 8'h05, 8'h06}, {6'd0, 6'd0, 6'd2, 6'd2});
    doVisit(0, 1, 0, 0);
    doVisit(0, 0, 0, 1);
    endPhase();

    // count clamp and zero-count skip
    setCfg(4'b0111, 4'b0001, {7'h00, 7'h3F, 7'h01, 7'h7E},
           {8'h00, 8'h20, 8'h21, 8'h22}, {6'd0, 6'd12, 6'd0, 6'd12});
    doVisit(0, 0, 2, 0);
    doVisit(0, 0, 2, 1);
    endPhase();

    for (int p = 0; p < 6; p++) begin
      logic [3:0] en, rw;
      logic [23:0] nb;
      int fc, nv, nNack;
      en = 4'($urandom); rw = 4'($urandom);
      for (int k = 0; k < NUM_CH; k++) nb[k*6 +: 6] = 6'($urandom_range(0, 12));
      fc = $urandom_range(0, NUM_CH - 1);
      en[fc] = 1'b1;
      if (nb[fc*6 +: 6] == 6'd0) nb[fc*6 +: 6] = 6'd1;
      setCfg(en, rw, 28'($urandom), 32'($urandom), nb);
      nv = $urandom_range(3, 7);
      for (int v = 0; v < nv; v++) begin
        nNack = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        doVisit(nNack, $urandom_range(0, 9) == 0, $urandom_range(0, 2), v == nv - 1);
      end
      endPhase();
    end

    // err_clr wipes a set flag
    setCfg(4'b0001, 4'b0001, 28'h0000012, 32'h0, {6'd0, 6'd0, 6'd0, 6'd2});
    doVisit(9, 0, 0, 1);
    endPhase();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; modelErr = '0;
    @(negedge clk);
    checkVal("err_clr", 64'(ch_err), 64'(modelErr));

    // reset mid-transaction on a non-zero pointer, then restart from ch0
    setCfg(4'b1111, 4'b1111, 28'($urandom), 32'($urandom), {4{6'd4}});
    do doVisit(0, 0, 0, 0); while (modelPtr == 0);
    waitGo(ok);
    checkVal("go_before_reset", 64'(ok), 64'd1);
    expGo++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("reset_mid_outputs", allOutputs(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    modelPtr = 0; modelErr = '0;
    checkVal("no_stop_on_reset", 64'(stopCnt), 64'(expStop));
    doVisit(0, 0, 1, 1);
    endPhase();

    for (int i = 0; i < NUM_CH * MAX_BYTES; i++)
      checkVal($sformatf("ram[%0d]", i), 64'(ram[i]), 64'(modelRam[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
